// File: rtl/dm_load_pkg.sv
// dm_load_pkg: shared pipeline definitions for the DM load path.
//   LD_* load type codes, AdEL exception code, default DM/device
//   boundary, load-unit state type and a type-normalising helper.
package dm_load_pkg;

    localparam logic [2:0]  LD_LW  = 3'd0;
    localparam logic [2:0]  LD_LH  = 3'd1;
    localparam logic [2:0]  LD_LHU = 3'd2;
    localparam logic [2:0]  LD_LB  = 3'd3;
    localparam logic [2:0]  LD_LBU = 3'd4;

    localparam logic [4:0]  EXC_ADEL = 5'd4;

    localparam logic [31:0] DM_LIMIT_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_t;

    // Unknown type codes behave as a plain word load.
    function automatic logic [2:0] ld_norm_type(input logic [2:0] t);
        return (t > LD_LBU) ? LD_LW : t;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// dm_load_ext: combinational byte/half/word extraction with sign or
//   zero extension.
//   rdata   in  32  raw word from memory
//   off     in  2   byte offset within the word (addr[1:0])
//   ld_type in  3   normalised LD_* type
//   value   out 32  extended load result
module dm_load_ext
    import dm_load_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  ld_type,
    output logic [31:0] value
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
        case (off)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        case (ld_type)
            LD_LH:   value = {{16{half_v[15]}}, half_v};
            LD_LHU:  value = {16'h0000, half_v};
            LD_LB:   value = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  value = {24'h00_0000, byte_v};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/dm_load_unit.sv
// dm_load_unit: M-stage load sequencer. Issues one read to DM/bridge,
//   waits for the response, extracts/extends the result and flags AdEL.
//   clk, reset            clock, synchronous active-high reset
//   req_valid/addr/type   load request from M stage (sampled in IDLE)
//   flush                 cancel the outstanding load
//   mem_req/mem_addr      read request (level) and word address
//   mem_rvalid/mem_rdata  read response pulse and data
//   busy                  pipe hold, high in WAIT and DRAIN
//   out_valid/data/adel   one-cycle result pulse, held data, AdEL flag
//
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | read issued, waiting for mem_rvalid
//   DRAIN | flushed while waiting; swallow the response
//   DONE  | out_valid pulse cycle
module dm_load_unit
    import dm_load_pkg::*;
#(
    parameter logic [31:0] DM_LIMIT = DM_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_type,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_adel
);

    ld_state_t   state;
    logic [1:0]  off_q;
    logic [2:0]  type_q;
    logic [2:0]  req_type_n;
    logic        req_adel;
    logic [31:0] ext_value;

    assign req_type_n = ld_norm_type(req_type);

    // Device space above DM_LIMIT only decodes full words.
    assign req_adel = ((req_type_n == LD_LW) && (req_addr[1:0] != 2'b00))
                    || (((req_type_n == LD_LH) || (req_type_n == LD_LHU)) && req_addr[0])
                    || ((req_addr >= DM_LIMIT) && (req_type_n != LD_LW));

    dm_load_ext u_ext (
        .rdata   (mem_rdata),
        .off     (off_q),
        .ld_type (type_q),
        .value   (ext_value)
    );

    assign busy = (state == ST_WAIT) || (state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            off_q     <= 2'b00;
            type_q    <= LD_LW;
            mem_req   <= 1'b0;
            mem_addr  <= 32'h0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            out_adel  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        off_q  <= req_addr[1:0];
                        type_q <= req_type_n;
                        if (req_adel) begin
                            out_valid <= 1'b1;
                            out_data  <= 32'h0;
                            out_adel  <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        mem_req <= 1'b0;
                        if (flush) begin
                            state <= ST_IDLE;
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= ext_value;
                            out_adel  <= 1'b0;
                            state     <= ST_DONE;
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mem_rvalid) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
